cdb_broadcaster: RTL

CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

---
 rtl/cdb_broadcaster.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: one result FIFO per source (ALU, MEM), arbitrated onto a single CDB.
// Define CDB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed MEM priority.
module cdb_broadcaster #(
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned QDEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              alu_valid,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_value,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [TAG_W-1:0]  mem_tag,
    input  logic [DATA_W-1:0] mem_value,
    output logic              mem_ready,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic              alu_stall,
    output logic              mem_stall
);
    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QDEPTH);

    logic [TAG_W-1:0]  alu_tag_mem [QDEPTH];
    logic [DATA_W-1:0] alu_val_mem [QDEPTH];
    logic [PTR_W-1:0]  alu_rd_q, alu_wr_q;
    logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d;

    logic [TAG_W-1:0]  mem_tag_mem [QDEPTH];
    logic [DATA_W-1:0] mem_val_mem [QDEPTH];
    logic [PTR_W-1:0]  mem_rd_q, mem_wr_q;
    logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;

    logic alu_push, mem_push, alu_pop, mem_pop;
    logic alu_nonempty, mem_nonempty, grant_mem;

    assign alu_ready    = alu_cnt_q < DEPTH_CNT;
    assign mem_ready    = mem_cnt_q < DEPTH_CNT;
    assign alu_stall    = ~alu_ready;
    assign mem_stall    = ~mem_ready;
    assign alu_nonempty = alu_cnt_q != '0;
    assign mem_nonempty = mem_cnt_q != '0;

    // Tag 0 is handshaken but never stored: it carries no dependency for consumers.
    assign alu_push = alu_valid & alu_ready & (alu_tag != '0) & ~flush;
    assign mem_push = mem_valid & mem_ready & (mem_tag != '0) & ~flush;
    assign alu_pop  = cdb_valid & ~grant_mem;
    assign mem_pop  = cdb_valid & grant_mem;

`ifdef CDB_ROUND_ROBIN_EN
    logic prio_q, prio_d;  // 0: ALU favoured, 1: MEM favoured

    always_comb begin
        grant_mem = mem_nonempty;
        if (alu_nonempty && mem_nonempty) grant_mem = prio_q;
    end

    always_comb begin
        prio_d = prio_q;
        if (cdb_valid && alu_nonempty && mem_nonempty) prio_d = ~prio_q;
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= 1'b0;
        else     prio_q <= prio_d;
    end
`else
    assign grant_mem = mem_nonempty;
`endif

    always_comb begin
        cdb_valid = (alu_nonempty | mem_nonempty) & ~flush;
        cdb_tag   = '0;
        cdb_value = '0;
        if (cdb_valid) begin
            if (grant_mem) begin
                cdb_tag   = mem_tag_mem[mem_rd_q];
                cdb_value = mem_val_mem[mem_rd_q];
            end else begin
                cdb_tag   = alu_tag_mem[alu_rd_q];
                cdb_value = alu_val_mem[alu_rd_q];
            end
        end
    end

    always_comb begin
        alu_cnt_d = alu_cnt_q;
        if (alu_push && !alu_pop)      alu_cnt_d = alu_cnt_q + 1'b1;
        else if (alu_pop && !alu_push) alu_cnt_d = alu_cnt_q - 1'b1;
        mem_cnt_d = mem_cnt_q;
        if (mem_push && !mem_pop)      mem_cnt_d = mem_cnt_q + 1'b1;
        else if (mem_pop && !mem_push) mem_cnt_d = mem_cnt_q - 1'b1;
    end

    // QDEPTH is a power of two, so pointers wrap naturally at QDEPTH-1.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            alu_rd_q  <= '0;
            alu_wr_q  <= '0;
            alu_cnt_q <= '0;
            mem_rd_q  <= '0;
            mem_wr_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (alu_push) alu_wr_q <= alu_wr_q + 1'b1;
            if (alu_pop)  alu_rd_q <= alu_rd_q + 1'b1;
            if (mem_push) mem_wr_q <= mem_wr_q + 1'b1;
            if (mem_pop)  mem_rd_q <= mem_rd_q + 1'b1;
            alu_cnt_q <= alu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (alu_push) begin
            alu_tag_mem[alu_wr_q] <= alu_tag;
            alu_val_mem[alu_wr_q] <= alu_value;
        end
        if (mem_push) begin
            mem_tag_mem[mem_wr_q] <= mem_tag;
            mem_val_mem[mem_wr_q] <= mem_value;
        end
    end

endmodule
